// File: rtl/spi_frame_serializer_pkg.sv
// Shared types and width helpers for the SPI frame serializer.
package spi_frame_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   function automatic int shift_w(input int opw, input int aw);
      return opw + aw;
   endfunction

   // Counter must hold SHIFT_W-1; a one-bit minimum keeps the vector legal.
   function automatic int cnt_w(input int sw);
      return (clog2(sw) < 1) ? 1 : clog2(sw);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Request FIFO: head visible combinationally, push/pop/flush take effect on the next edge.
// Push while full and pop while empty are ignored; flush wins over a same-cycle push.
module sync_fifo
   import spi_frame_serializer_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push,
   input  logic [WIDTH-1:0]            i_dat,
   input  logic                        i_pop,
   input  logic                        i_flush,
   output logic [WIDTH-1:0]            o_dat,
   output logic [clog2(DEPTH+1)-1:0]   o_level
);
   localparam int AW   = clog2(DEPTH);
   localparam int LVLW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [LVLW-1:0]  r_level;
   logic             w_push, w_pop;

   assign w_push  = i_push && (r_level != LVLW'(DEPTH));
   assign w_pop   = i_pop && (r_level != '0);
   assign o_dat   = r_mem[r_rptr];
   assign o_level = r_level;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_dat;
   end

   // Occupancy is kept separately so a full FIFO never aliases to empty.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spi_frame_serializer.sv
// Queues {opcode,addr} requests and shifts them out on miso, one bit per synchronised spi_clk launch edge.
// First bit one cycle after the pop; ready_out drops when the FIFO is full, n_cs high mid-frame aborts.
module spi_frame_serializer
   import spi_frame_serializer_pkg::*;
#(
   parameter int ADDRW          = 8,
   parameter int OPCODEW        = 2,
   parameter int DEPTH          = 4,
   parameter int LSB_FIRST      = 0,
   parameter int CPOL           = 0,
   parameter int FLUSH_ON_ABORT = 0
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        n_cs,
   input  logic                        spi_clk,
   input  logic                        valid_in,
   input  logic [OPCODEW-1:0]          opcode,
   input  logic [ADDRW-1:0]            addr,
   output logic                        ready_out,
   output logic                        miso,
   output logic                        busy,
   output logic [clog2(DEPTH+1)-1:0]   level,
   output logic                        err
);
   localparam int   SHIFT_W  = shift_w(OPCODEW, ADDRW);
   localparam int   CNTW     = cnt_w(SHIFT_W);
   localparam int   LVLW     = clog2(DEPTH + 1);
   localparam logic SCK_IDLE = (CPOL != 0);

   state_t             r_state, w_state_nxt;
   logic               r_cs_s1, r_cs_s2, r_sck_s1, r_sck_s2, r_sck_d;
   logic [SHIFT_W-1:0] r_shreg, w_shreg_nxt, w_head, w_head_rest, w_sh_rest;
   logic               w_head_first, w_sh_first;
   logic [CNTW-1:0]    r_cnt, w_cnt_nxt;
   logic               r_miso, r_busy, r_err;
   logic               w_miso_nxt, w_busy_nxt, w_err_nxt;
   logic               w_launch, w_pop, w_flush, w_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_s1  <= 1'b1;
         r_cs_s2  <= 1'b1;
         r_sck_s1 <= SCK_IDLE;
         r_sck_s2 <= SCK_IDLE;
         r_sck_d  <= SCK_IDLE;
      end else begin
         r_cs_s1  <= n_cs;
         r_cs_s2  <= r_cs_s1;
         r_sck_s1 <= spi_clk;
         r_sck_s2 <= r_sck_s1;
         r_sck_d  <= r_sck_s2;
      end
   end

   assign w_launch = (CPOL != 0) ? (r_sck_s2 && !r_sck_d) : (!r_sck_s2 && r_sck_d);

   assign ready_out = (level != LVLW'(DEPTH));
   assign w_push    = valid_in && ready_out;

   sync_fifo #(
      .WIDTH (SHIFT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_dat   ({opcode, addr}),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_dat   (w_head),
      .o_level (level)
   );

   // The shift register always holds the bits still to send, aligned for the chosen order.
   assign w_head_first = (LSB_FIRST != 0) ? w_head[0]  : w_head[SHIFT_W-1];
   assign w_head_rest  = (LSB_FIRST != 0) ? (w_head >> 1)  : (w_head << 1);
   assign w_sh_first   = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[SHIFT_W-1];
   assign w_sh_rest    = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_miso  <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_miso  <= w_miso_nxt;
         r_busy  <= w_busy_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      w_miso_nxt  = r_miso;
      w_busy_nxt  = r_busy;
      w_err_nxt   = 1'b0;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_miso_nxt = 1'b0;
            w_busy_nxt = 1'b0;
            if (!r_cs_s2 && (level != '0)) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SHIFT;
               w_miso_nxt  = w_head_first;
               w_shreg_nxt = w_head_rest;
               w_cnt_nxt   = CNTW'(SHIFT_W - 1);
               w_busy_nxt  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_cs_s2) begin
               w_state_nxt = ST_IDLE;
               w_err_nxt   = 1'b1;
               w_miso_nxt  = 1'b0;
               w_busy_nxt  = 1'b0;
               w_flush     = (FLUSH_ON_ABORT != 0);
            end else if (w_launch) begin
               if (r_cnt != '0) begin
                  w_miso_nxt  = w_sh_first;
                  w_shreg_nxt = w_sh_rest;
                  w_cnt_nxt   = r_cnt - 1'b1;
               end else if (level != '0) begin
                  w_pop       = 1'b1;
                  w_miso_nxt  = w_head_first;
                  w_shreg_nxt = w_head_rest;
                  w_cnt_nxt   = CNTW'(SHIFT_W - 1);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_miso_nxt  = 1'b0;
                  w_busy_nxt  = 1'b0;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign miso = r_miso;
   assign busy = r_busy;
   assign err  = r_err;

endmodule

// File: doc/spi_frame_serializer.md
SPI_FRAME_SERIALIZER -- requirements
Module: spi_frame_serializer

Interface
REQ-001 Parameter ADDRW, default 8, address field width in bits (>=1).
REQ-002 Parameter OPCODEW, default 2, opcode field width in bits (>=1).
REQ-003 Parameter DEPTH, default 4, request FIFO entries (power of 2, >=2).
REQ-004 Parameter LSB_FIRST, default 0; 0 = MSB of {opcode,addr} first, 1 = LSB first.
REQ-005 Parameter CPOL, default 0; 0 = launch on spi_clk falling edge, 1 = launch on rising edge.
REQ-006 Parameter FLUSH_ON_ABORT, default 0; 1 = empty the FIFO on frame abort.
REQ-007 clk  in  1  sole system clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous to clk and active-high.
REQ-009 n_cs  in  1  async chip select, active-low.
REQ-010 spi_clk  in  1  async SPI clock, frequency below clk/4.
REQ-011 valid_in  in  1  request valid.
REQ-012 opcode  in  OPCODEW  request opcode.
REQ-013 addr  in  ADDRW  request address.
REQ-014 ready_out  out  1  FIFO can accept a request.
REQ-015 miso  out  1  serial data.
REQ-016 busy  out  1  frame in progress.
REQ-017 level  out  clog2(DEPTH+1)  FIFO occupancy.
REQ-018 err  out  1  one-cycle abort pulse.

Function
REQ-019 spi_clk and n_cs are each synchronised through 2 flops; launch edge is detected on the synchronised spi_clk per CPOL.
REQ-020 Frame word W = {opcode,addr}, SHIFT_W = OPCODEW+ADDRW bits.
REQ-021 ready_out = (level != DEPTH), combinational from registered state.
REQ-022 Push occurs when valid_in && ready_out on a clk edge; a push while full is ignored with no other effect.
REQ-023 FSM states IDLE, SHIFT.
REQ-024 IDLE -> SHIFT when synchronised n_cs is low and level != 0 at cycle start: pop the head, drive the first bit on miso the next cycle, load the bit counter with SHIFT_W-1, set busy.
REQ-025 In SHIFT, each launch edge drives the next bit on miso and decrements the counter.
REQ-026 On the launch edge with counter 0, either pop the next word (if level != 0) and drive its first bit in the same cycle, staying in SHIFT back-to-back, or go to IDLE with miso=0 and busy=0.
REQ-027 A pop and a push in the same cycle leave level unchanged; a word pushed into an empty FIFO is poppable no earlier than the following cycle.
REQ-028 Abort: synchronised n_cs high while in SHIFT -> IDLE next cycle, err=1 for exactly one cycle, miso=0, busy=0, current word discarded.
REQ-029 On abort, the FIFO is emptied if FLUSH_ON_ABORT=1, else retained.
REQ-030 Synchronised n_cs high in IDLE has no effect other than blocking pops; err stays 0.
REQ-031 level wraps never: read and write pointers are log2(DEPTH) bits and occupancy is tracked separately.

Reset
REQ-032 While rst=1 at a clk edge: FIFO empty, level=0, ready_out=1, miso=0, busy=0, err=0, FSM=IDLE, synchroniser flops = idle level (n_cs 1, spi_clk CPOL).
REQ-033 Reset mid-frame terminates the frame silently, with no err pulse.
REQ-034 The first push is accepted on the first clk edge after rst deasserts.

Structure
REQ-035 A shared package holds the FSM state enum, the clog2 function, and the SHIFT_W and counter-width calculations.
REQ-036 The FIFO is one sub-module, sync_fifo (parameters WIDTH, DEPTH); synchronisers and FSM live in the top.

Verification
REQ-037 Defaults, n_cs low, push opcode=2'b10 addr=8'hA5 -> miso bits 1,0,1,0,1,0,0,1,0,1 on 10 successive falling edges; then busy=0, miso=0.
REQ-038 LSB_FIRST=1, same word -> miso 1,0,1,0,0,1,0,1,0,1.
REQ-039 n_cs high, push 5 words -> ready_out=0 after the 4th, 5th dropped, level=4; drop n_cs -> 4 back-to-back 10-bit frames, no idle edge between them.
REQ-040 Raise n_cs after 4 bits -> err high exactly 1 cycle, busy=0, level=3 (FLUSH_ON_ABORT=0) or 0 (FLUSH_ON_ABORT=1).
REQ-041 Assert rst mid-frame with level=2 -> next cycle level=0, ready_out=1, miso=0, err=0.
REQ-042 CPOL=1, same stimulus as REQ-037 -> identical bit sequence, each bit launched on a rising spi_clk edge.
